// File: rtl/jogo_fisica_if.sv
// jogo_fisica_if: debounced keys in, bar/ball/score state out towards the renderer
interface jogo_fisica_if;
    logic       esquerda;
    logic       direita;
    logic       lancar;
    logic [9:0] BordaBarraX;
    logic [8:0] BordaBarraY;
    logic [9:0] BolaX;
    logic [8:0] BolaY;
    logic       perdeu;
    logic [7:0] pontos;
    modport master (output esquerda, direita, lancar,
                    input BordaBarraX, BordaBarraY, BolaX, BolaY, perdeu, pontos);
    modport slave  (input esquerda, direita, lancar,
                    output BordaBarraX, BordaBarraY, BolaX, BolaY, perdeu, pontos);
endinterface

// File: rtl/jogo_fisica.sv
// jogo_fisica: breakout physics, bar motion, ball bounce and loss detection per frame tick
module jogo_fisica #(
    parameter int LARGURA_TELA = 640,
    parameter int ALTURA_TELA  = 480,
    parameter int LarguraBarra = 80,
    parameter int BARRA_Y      = 450,
    parameter int LadoBola     = 8,
    parameter int VEL_BARRA    = 4,
    parameter int VEL_BOLA     = 2,
    parameter int TICK_DIV     = 833333
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    jogo_fisica_if.slave  io
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [10:0] BAR_MAX = 11'(LARGURA_TELA - LarguraBarra);
    localparam logic [10:0] BAR_INI = 11'((LARGURA_TELA - LarguraBarra) / 2);
    localparam logic [10:0] GLUE    = 11'((LarguraBarra - LadoBola) / 2);
    localparam logic [10:0] BX_MAX  = 11'(LARGURA_TELA - LadoBola);
    localparam logic [10:0] BY_GLUE = 11'(BARRA_Y - LadoBola);
    localparam logic [10:0] BY_MAX  = 11'(ALTURA_TELA - LadoBola);
    localparam logic [10:0] BY_BAR  = 11'(BARRA_Y);
    localparam logic [10:0] VB      = 11'(VEL_BOLA);
    localparam logic [10:0] VBAR    = 11'(VEL_BARRA);
    localparam logic [10:0] LB      = 11'(LadoBola);
    localparam logic [10:0] LBAR    = 11'(LarguraBarra);

    typedef enum logic [1:0] {ESPERA, JOGANDO, PERDEU} estado_t;

    estado_t        estado, estado_n;
    logic [CW-1:0]  cnt;
    logic           tick;
    logic [9:0]     bar_x, bar_n, bx, bx_n, bar_mov, x_tick;
    logic [8:0]     by, by_n, y_tick;
    logic           dx, dx_n, dy, dy_n, dx_tick, dy_tick;
    logic [7:0]     pts, pts_n;
    logic [10:0]    b, bxm, bym;
    logic           top, hit, lost;

    assign tick = cnt == CW'(TICK_DIV - 1);
    assign b    = {1'b0, bar_x};
    assign bxm  = {1'b0, bx};
    assign bym  = {2'b0, by};

    assign bar_mov = (io.esquerda & ~io.direita) ? 10'(b < VBAR ? 11'd0 : b - VBAR) :
                     (io.direita & ~io.esquerda) ? 10'(b + VBAR > BAR_MAX ? BAR_MAX : b + VBAR) :
                     bar_x;

    assign x_tick  = (!dx && bxm < VB) ? 10'd0 :
                     (dx && bxm + VB > BX_MAX) ? 10'(BX_MAX) :
                     dx ? 10'(bxm + VB) : 10'(bxm - VB);
    assign dx_tick = (!dx && bxm < VB) ? 1'b1 : (dx && bxm + VB > BX_MAX) ? 1'b0 : dx;

    assign top  = !dy && bym < VB;
    assign hit  = dy && bym + LB <= BY_BAR && bym + LB + VB >= BY_BAR &&
                  bxm + LB > b && bxm < b + LBAR;
    assign lost = dy && !hit && bym + VB >= BY_MAX;

    assign y_tick  = top ? 9'd0 : hit ? 9'(BY_GLUE) : lost ? 9'(BY_MAX) :
                     dy ? 9'(bym + VB) : 9'(bym - VB);
    assign dy_tick = top ? 1'b1 : hit ? 1'b0 : dy;

    // frame tick divider, restarts from zero on reset
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end

    // next-state and next-position decisions for each game phase
    always_comb begin
        estado_n = estado;
        bar_n    = bar_x;
        bx_n     = bx;
        by_n     = by;
        dx_n     = dx;
        dy_n     = dy;
        pts_n    = pts;
        case (estado)
            ESPERA: begin
                bar_n = tick ? bar_mov : bar_x;
                bx_n  = bar_n + GLUE[9:0];
                by_n  = BY_GLUE[8:0];
                dx_n  = 1'b1;
                dy_n  = 1'b0;
                estado_n = io.lancar ? JOGANDO : ESPERA;
            end
            JOGANDO: if (tick) begin
                bar_n = bar_mov;
                bx_n  = x_tick;
                by_n  = y_tick;
                dx_n  = dx_tick;
                dy_n  = dy_tick;
                pts_n = (hit && pts != 8'hFF) ? pts + 8'd1 : pts;
                estado_n = lost ? PERDEU : JOGANDO;
            end
            PERDEU: if (io.lancar) begin
                estado_n = ESPERA;
                pts_n = 8'd0;
                bx_n  = bar_x + GLUE[9:0];
                by_n  = BY_GLUE[8:0];
                dx_n  = 1'b1;
                dy_n  = 1'b0;
            end
            default: estado_n = ESPERA;
        endcase
    end

    // game state registers; ball starts glued to the centred bar, heading up-right
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            estado <= ESPERA;
            bar_x  <= BAR_INI[9:0];
            bx     <= BAR_INI[9:0] + GLUE[9:0];
            by     <= BY_GLUE[8:0];
            dx     <= 1'b1;
            dy     <= 1'b0;
            pts    <= 8'd0;
        end else begin
            estado <= estado_n;
            bar_x  <= bar_n;
            bx     <= bx_n;
            by     <= by_n;
            dx     <= dx_n;
            dy     <= dy_n;
            pts    <= pts_n;
        end
    end

    assign io.BordaBarraX = bar_x;
    assign io.BordaBarraY = 9'(BARRA_Y);
    assign io.BolaX       = bx;
    assign io.BolaY       = by;
    assign io.perdeu      = estado == PERDEU;
    assign io.pontos      = pts;
endmodule
